// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle Small-MIPS control path: opcodes, ALU-op codes,
// mux select codes, FSM state encoding and the packed control-word layout.
package multicycle_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU-op field handed to the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // PC source mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU operand B mux
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_FETCH  = 4'd1;
  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_MEMADR = 4'd3;
  localparam logic [3:0] ST_MEMRD  = 4'd4;
  localparam logic [3:0] ST_MEMWB  = 4'd5;
  localparam logic [3:0] ST_MEMWR  = 4'd6;
  localparam logic [3:0] ST_EXEC   = 4'd7;
  localparam logic [3:0] ST_ALUWB  = 4'd8;
  localparam logic [3:0] ST_BRANCH = 4'd9;
  localparam logic [3:0] ST_ADDIEX = 4'd10;
  localparam logic [3:0] ST_ADDIWB = 4'd11;
  localparam logic [3:0] ST_JUMP   = 4'd12;
  localparam logic [3:0] ST_ERR    = 4'd13;

  // One control word per cycle; fields map 1:1 onto the top-level outputs
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic       bus_err;
  } ctrl_t;

  // True for every opcode the core implements
  function automatic logic opcode_legal(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_J) || (opcode == OP_BEQ) ||
           (opcode == OP_ADDI) || (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive memory wait-cycle counter with timeout compare. o_expired fires on the
// TIMEOUT_CYCLES-th consecutive wait cycle, so the FSM can leave in that same cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_wait,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LastWait = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority; otherwise count each wait cycle
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_wait) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Wait already excludes ready, so a last-cycle ready never expires
  assign o_expired = i_wait && (cnt_q == LastWait);

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle Small-MIPS core. One step per cycle; memory
// accesses stall on i_memReady and fall into an absorbing error state on timeout.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_memReady,
  output logic       o_memReq,
  output logic       o_memWrite,
  output logic       o_iOrD,
  output logic       o_irWrite,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic [1:0] o_pcSrc,
  output logic [1:0] o_aluOp,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic       o_regWrite,
  output logic       o_regDst,
  output logic       o_memToReg,
  output logic       o_illegal,
  output logic       o_busErr
);

  logic [3:0] state_q, state_d;
  ctrl_t      ctrl;
  logic       wait_cycle;
  logic       timer_clear;
  logic       timer_expired;

  // The beq decision is taken in the datapath by ANDing pcWriteCond with zero
  logic unused_zero;
  assign unused_zero = i_zero;

  // Moore output decode; only FETCH's IR/PC loads are qualified by ready
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = i_memReady;
        ctrl.pc_write  = i_memReady;
      end
      ST_DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.illegal   = !opcode_legal(i_opcode);
      end
      ST_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.i_or_d  = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
      end
      ST_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
      end
      ST_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PCSRC_JUMP;
      end
      ST_ERR: begin
        ctrl.bus_err = 1'b1;
      end
      default: ;
    endcase
  end

  // A wait cycle is an outstanding request without ready; any cycle that is not a
  // wait cycle restarts the count, which also covers entry into each access state
  assign wait_cycle  = ctrl.mem_req && !i_memReady;
  assign timer_clear = !ctrl.mem_req || i_memReady;

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_mem_wait_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (timer_clear),
    .i_wait   (wait_cycle),
    .o_expired(timer_expired)
  );

  // Next-state logic; in memory states ready is checked before the timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (i_memReady)         state_d = ST_DECODE;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (i_opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD: begin
        if (i_memReady)         state_d = ST_MEMWB;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR: begin
        if (i_memReady)         state_d = ST_FETCH;
        else if (timer_expired) state_d = ST_ERR;
      end
      ST_EXEC:   state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_ADDIEX: state_d = ST_ADDIWB;
      ST_ADDIWB: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; async reset drops any request in flight immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output mapping
  assign o_memReq      = ctrl.mem_req;
  assign o_memWrite    = ctrl.mem_write;
  assign o_iOrD        = ctrl.i_or_d;
  assign o_irWrite     = ctrl.ir_write;
  assign o_pcWrite     = ctrl.pc_write;
  assign o_pcWriteCond = ctrl.pc_write_cond;
  assign o_pcSrc       = ctrl.pc_src;
  assign o_aluOp       = ctrl.alu_op;
  assign o_aluSrcA     = ctrl.alu_src_a;
  assign o_aluSrcB     = ctrl.alu_src_b;
  assign o_regWrite    = ctrl.reg_write;
  assign o_regDst      = ctrl.reg_dst;
  assign o_memToReg    = ctrl.mem_to_reg;
  assign o_illegal     = ctrl.illegal;
  assign o_busErr      = ctrl.bus_err;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each scenario queues (inputs, expected
// control word) steps, then drives them one per cycle and compares mid-cycle.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, alu_op, alu_src_b;
  logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal, bus_err;
  logic [17:0] obs;

  int checks   = 0;
  int failures = 0;

  // Bench-side state names for the expectation table
  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4;
  localparam int S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_ALUWB = 8, S_BRANCH = 9;
  localparam int S_ADDIEX = 10, S_ADDIWB = 11, S_JUMP = 12, S_ERR = 13;

  typedef struct {
    string       tag;
    logic        ready;
    logic [5:0]  opc;
    logic [17:0] exp;
  } step_t;

  step_t sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_memReady   (mem_ready),
    .o_memReq     (mem_req),
    .o_memWrite   (mem_write),
    .o_iOrD       (i_or_d),
    .o_irWrite    (ir_write),
    .o_pcWrite    (pc_write),
    .o_pcWriteCond(pc_write_cond),
    .o_pcSrc      (pc_src),
    .o_aluOp      (alu_op),
    .o_aluSrcA    (alu_src_a),
    .o_aluSrcB    (alu_src_b),
    .o_regWrite   (reg_write),
    .o_regDst     (reg_dst),
    .o_memToReg   (mem_to_reg),
    .o_illegal    (illegal),
    .o_busErr     (bus_err)
  );

  // {memReq,memWrite,iOrD,irWrite,pcWrite,pcWriteCond,pcSrc,aluOp,aluSrcA,aluSrcB,
  //  regWrite,regDst,memToReg,illegal,busErr}
  assign obs = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                alu_op, alu_src_a, alu_src_b, reg_write, reg_dst, mem_to_reg, illegal,
                bus_err};

  // Expected control word per state, straight from the behaviour table
  function automatic logic [17:0] exp_of(input int st, input logic rdy, input logic ill);
    logic [17:0] e;
    e = '0;
    case (st)
      S_FETCH:  begin e[17] = 1'b1; e[14] = rdy; e[13] = rdy; e[6:5] = 2'b01; end
      S_DECODE: begin e[6:5] = 2'b11; e[1] = ill; end
      S_MEMADR: begin e[7] = 1'b1; e[6:5] = 2'b10; end
      S_MEMRD:  begin e[17] = 1'b1; e[15] = 1'b1; end
      S_MEMWB:  begin e[4] = 1'b1; e[2] = 1'b1; end
      S_MEMWR:  begin e[17:15] = 3'b111; end
      S_EXEC:   begin e[7] = 1'b1; e[9:8] = 2'b10; end
      S_ALUWB:  begin e[4] = 1'b1; e[3] = 1'b1; end
      S_BRANCH: begin e[7] = 1'b1; e[9:8] = 2'b01; e[12] = 1'b1; e[11:10] = 2'b01; end
      S_ADDIEX: begin e[7] = 1'b1; e[6:5] = 2'b10; end
      S_ADDIWB: begin e[4] = 1'b1; end
      S_JUMP:   begin e[13] = 1'b1; e[11:10] = 2'b10; end
      S_ERR:    begin e[0] = 1'b1; end
      default:  ;
    endcase
    return e;
  endfunction

  task automatic push(input string tag, input int st, input logic rdy, input logic [5:0] opc,
                      input logic ill = 1'b0);
    step_t s;
    s.tag = tag;
    s.ready = rdy;
    s.opc = opc;
    s.exp = exp_of(st, rdy, ill);
    sb.push_back(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; zero = 1'b0;
    #1;
    checks++;
    if (obs !== 18'h0) begin
      failures++; $display("FAIL reset_outputs: got %h want %h", obs, 18'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0) begin
      failures++; $display("FAIL idle_outputs: got %h want %h", obs, 18'h0);
    end
  endtask

  task automatic test_rtype();
    step_t s;
    push("rt_fetch", S_FETCH, 1'b1, 6'h00);
    push("rt_decode", S_DECODE, 1'b1, 6'h00);
    push("rt_exec", S_EXEC, 1'b1, 6'h00);
    push("rt_aluwb", S_ALUWB, 1'b1, 6'h00);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_lw_wait();
    step_t s;
    int memrd_cycles;
    memrd_cycles = 0;
    push("lw_fetch", S_FETCH, 1'b1, 6'h23);
    push("lw_decode", S_DECODE, 1'b1, 6'h23);
    push("lw_memadr", S_MEMADR, 1'b1, 6'h23);
    for (int i = 0; i < 3; i++) push("lw_memrd_wait", S_MEMRD, 1'b0, 6'h23);
    push("lw_memrd_ready", S_MEMRD, 1'b1, 6'h23);
    push("lw_memwb", S_MEMWB, 1'b1, 6'h23);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      if (mem_req && i_or_d) memrd_cycles++;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
    checks++;
    if (memrd_cycles !== 4) begin
      failures++; $display("FAIL lw_memreq_len: got %0d want %0d", memrd_cycles, 4);
    end
  endtask

  task automatic test_sw_beq();
    step_t s;
    push("sw_fetch", S_FETCH, 1'b1, 6'h2B);
    push("sw_decode", S_DECODE, 1'b1, 6'h2B);
    push("sw_memadr", S_MEMADR, 1'b1, 6'h2B);
    push("sw_memwr", S_MEMWR, 1'b1, 6'h2B);
    push("beq_fetch", S_FETCH, 1'b1, 6'h04);
    push("beq_decode", S_DECODE, 1'b1, 6'h04);
    push("beq_branch", S_BRANCH, 1'b1, 6'h04);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; zero = 1'b1; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_back_to_back();
    step_t s;
    push("addi_fetch", S_FETCH, 1'b1, 6'h08);
    push("addi_decode", S_DECODE, 1'b1, 6'h08);
    push("addi_ex", S_ADDIEX, 1'b1, 6'h08);
    push("addi_wb", S_ADDIWB, 1'b1, 6'h08);
    push("j_fetch", S_FETCH, 1'b1, 6'h02);
    push("j_decode", S_DECODE, 1'b1, 6'h02);
    push("j_jump", S_JUMP, 1'b1, 6'h02);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s;
    int ill_cycles;
    ill_cycles = 0;
    push("ill_fetch", S_FETCH, 1'b1, 6'h3F);
    push("ill_decode", S_DECODE, 1'b1, 6'h3F, 1'b1);
    push("ill_refetch", S_FETCH, 1'b0, 6'h3F);
    push("ill_refetch_rdy", S_FETCH, 1'b1, 6'h3F);
    push("ill_decode2", S_DECODE, 1'b1, 6'h3F, 1'b1);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      if (illegal) ill_cycles++;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
    checks++;
    if (ill_cycles !== 2) begin
      failures++; $display("FAIL ill_pulse_count: got %0d want %0d", ill_cycles, 2);
    end
  endtask

  task automatic test_timeout_edge();
    step_t s;
    for (int i = 0; i < 15; i++) push("edge_fetch_wait", S_FETCH, 1'b0, 6'h02);
    push("edge_fetch_rdy16", S_FETCH, 1'b1, 6'h02);
    push("edge_decode", S_DECODE, 1'b1, 6'h02);
    push("edge_jump", S_JUMP, 1'b1, 6'h02);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    step_t s;
    push("rw_fetch", S_FETCH, 1'b1, 6'h2B);
    push("rw_decode", S_DECODE, 1'b1, 6'h2B);
    push("rw_memadr", S_MEMADR, 1'b1, 6'h2B);
    push("rw_memwr_wait", S_MEMWR, 1'b0, 6'h2B);
    push("rw_memwr_wait", S_MEMWR, 1'b0, 6'h2B);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_write} !== 2'b00) begin
      failures++; $display("FAIL rw_req_drop: got %b want %b", {mem_req, mem_write}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0) begin
      failures++; $display("FAIL rw_idle: got %h want %h", obs, 18'h0);
    end
    push("rw_resume_fetch", S_FETCH, 1'b1, 6'h00);
    push("rw_resume_decode", S_DECODE, 1'b1, 6'h00);
    push("rw_resume_exec", S_EXEC, 1'b1, 6'h00);
    push("rw_resume_aluwb", S_ALUWB, 1'b1, 6'h00);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic test_timeout();
    step_t s;
    for (int i = 0; i < 16; i++) push("to_fetch_wait", S_FETCH, 1'b0, 6'h00);
    push("to_err", S_ERR, 1'b0, 6'h00);
    push("to_err_sticky_rdy", S_ERR, 1'b1, 6'h00);
    push("to_err_sticky", S_ERR, 1'b0, 6'h23);
    push("to_err_sticky2", S_ERR, 1'b1, 6'h2B);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(negedge clk); mem_ready = s.ready; opcode = s.opc; #1;
      checks++;
      if (obs !== s.exp) begin
        failures++; $display("FAIL %s: got %h want %h", s.tag, obs, s.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_beq();
    test_back_to_back();
    test_illegal();
    test_timeout_edge();
    test_reset_mid_wait();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
